// File: rtl/jt49_bus_master_if.sv
// Request/response and PSG-side bus of jt49_bus_master.
// "master" is the view taken by jt49_bus_master itself (it accepts requests
// and drives the PSG core); "slave" is the view of whoever feeds it requests
// and models the PSG core.
interface jt49_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [3:0] req_addr;
  logic [7:0] req_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic       psg_cs_n;
  logic       psg_wr_n;
  logic [3:0] psg_addr;
  logic [7:0] psg_din;
  logic [7:0] psg_dout;

  modport master (
    input  req_valid, req_wr, req_addr, req_data, psg_dout,
    output req_ready, rd_valid, rd_data, busy,
           psg_cs_n, psg_wr_n, psg_addr, psg_din
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_data, psg_dout,
    input  req_ready, rd_valid, rd_data, busy,
           psg_cs_n, psg_wr_n, psg_addr, psg_din
  );
endinterface

// File: rtl/jt49_bus_master.sv
// Queues PSG register accesses in a small FIFO and plays each one out on the
// PSG bus as SETUP (1 tick), STROBE (HOLD ticks) and RECOVER (GAP ticks),
// where a tick is a clk edge with cen=1. Reads return the core data on the
// tick that leaves STROBE.
module jt49_bus_master #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 2,
  parameter int GAP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  jt49_bus_master_if.master bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int TMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_flag_q, wr_flag_d;
  logic          psg_cs_n_q, psg_cs_n_d, psg_wr_n_q, psg_wr_n_d;
  logic [3:0]    psg_addr_q, psg_addr_d;
  logic [7:0]    psg_din_q, psg_din_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic          full_s, empty_s, push_s, pop_s, start_s;
  entry_t        head_s;

  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == '0);
  assign push_s  = bus.req_valid & ~full_s;
  assign head_s  = mem_q[rd_ptr_q];

  assign bus.req_ready = ~full_s;
  assign bus.busy      = (state_q != ST_IDLE) | ~empty_s;
  assign bus.psg_cs_n  = psg_cs_n_q;
  assign bus.psg_wr_n  = psg_wr_n_q;
  assign bus.psg_addr  = psg_addr_q;
  assign bus.psg_din   = psg_din_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;

  // FIFO next state: push on any clk edge, pop only when the FSM starts an access.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = '{wr: bus.req_wr, addr: bus.req_addr, data: bus.req_data};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM next state, access latching and read capture; everything advances on cen only.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_flag_d  = wr_flag_q;
    psg_addr_d = psg_addr_q;
    psg_din_d  = psg_din_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    pop_s      = 1'b0;
    start_s    = 1'b0;
    if (cen) begin
      case (state_q)
        ST_IDLE: begin
          start_s = ~empty_s;
        end
        ST_SETUP: begin
          state_d = ST_STROBE;
          cnt_d   = '0;
        end
        ST_STROBE: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_RECOVER;
            cnt_d   = '0;
            if (!wr_flag_q) begin
              rd_data_d  = bus.psg_dout;
              rd_valid_d = 1'b1;
            end else begin
              rd_data_d  = rd_data_q;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RECOVER: begin
          if (cnt_q == GAP_LAST) begin
            // A queued request goes straight to SETUP with no IDLE tick between.
            if (!empty_s) begin
              start_s = 1'b1;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
      if (start_s) begin
        pop_s      = 1'b1;
        state_d    = ST_SETUP;
        cnt_d      = '0;
        wr_flag_d  = head_s.wr;
        psg_addr_d = head_s.addr;
        psg_din_d  = head_s.data;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      state_d = state_q;
    end

    // Strobes follow the state being entered so they are registered with it.
    case (state_d)
      ST_SETUP: begin
        psg_cs_n_d = 1'b0;
        psg_wr_n_d = 1'b1;
      end
      ST_STROBE: begin
        psg_cs_n_d = 1'b0;
        psg_wr_n_d = ~wr_flag_d;
      end
      default: begin
        psg_cs_n_d = 1'b1;
        psg_wr_n_d = 1'b1;
      end
    endcase
  end

  // State registers; rst empties the queue and aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_flag_q  <= 1'b0;
      psg_cs_n_q <= 1'b1;
      psg_wr_n_q <= 1'b1;
      psg_addr_q <= 4'h0;
      psg_din_q  <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_flag_q  <= wr_flag_d;
      psg_cs_n_q <= psg_cs_n_d;
      psg_wr_n_q <= psg_wr_n_d;
      psg_addr_q <= psg_addr_d;
      psg_din_q  <= psg_din_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: doc/jt49_bus_master.md
JT49_BUS_MASTER -- requirements
Module: jt49_bus_master

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter HOLD, default 2, number of cen ticks the access strobe stays active; SHALL be at least 1.
REQ-003 Parameter GAP, default 1, number of cen ticks of bus idle after each access; SHALL be at least 1.
REQ-004 clk  in  1  system clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cen  in  1  clock enable for all bus-side state advance (FSM, counters, psg_* outputs).
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  FIFO can accept a request.
REQ-009 req_wr  in  1  1 = register write, 0 = register read.
REQ-010 req_addr  in  4  PSG register index.
REQ-011 req_data  in  8  write data; ignored for reads.
REQ-012 rd_valid  out  1  one-clk pulse: rd_data holds a new read result.
REQ-013 rd_data  out  8  last read result.
REQ-014 busy  out  1  FIFO non-empty or access in progress.
REQ-015 psg_cs_n, psg_wr_n  out  1 each  active-low chip select and write strobe to the PSG core.
REQ-016 psg_addr  out  4; psg_din  out  8  address and write data to the PSG core.
REQ-017 psg_dout  in  8  PSG read data, registered by the core.

Function
REQ-018 A request SHALL be accepted on any clk edge with req_valid & req_ready, independent of cen; req_ready = !full.
REQ-019 The FIFO SHALL preserve request order; pointers SHALL wrap modulo DEPTH; a full FIFO SHALL drop nothing, because req_ready is low.
REQ-020 The FSM SHALL have the states IDLE, SETUP, STROBE and RECOVER, and SHALL change state only on edges where cen=1.
REQ-021 IDLE -> SETUP on a cen edge with the FIFO non-empty; the head entry SHALL be popped and latched into psg_addr and psg_din, plus an internal wr flag, on that edge.
REQ-022 SETUP lasts 1 cen tick: psg_cs_n=0, psg_wr_n=1. This guarantees the core sees wr_n high before the write strobe, which it needs for write-edge detection.
REQ-023 STROBE lasts HOLD cen ticks: psg_cs_n=0; psg_wr_n=0 for writes, 1 for reads.
REQ-024 RECOVER lasts GAP cen ticks with psg_cs_n=1 and psg_wr_n=1, then -> IDLE.
REQ-025 For a read, on the cen edge leaving STROBE, rd_data SHALL load psg_dout and rd_valid SHALL be 1 for exactly that following clk cycle.
REQ-026 psg_addr and psg_din SHALL be held stable from SETUP through the end of RECOVER.
REQ-027 The tick counter SHALL be wide enough for max(HOLD,GAP) without wrap.
REQ-028 Minimum access length SHALL be 1+HOLD+GAP cen ticks; back-to-back requests SHALL start SETUP on the cen tick right after RECOVER ends, with no extra IDLE tick.
REQ-029 Push and pop on the same edge SHALL keep the occupancy unchanged.
REQ-030 A push into an empty FIFO while the FSM is in IDLE SHALL be popped no earlier than the next cen edge.
REQ-031 busy SHALL equal (state != IDLE) | !empty.
REQ-032 With cen held at 0, the FSM and the psg_* outputs SHALL freeze; the FIFO SHALL still accept requests until full.

Reset
REQ-033 While rst=1: FIFO empty, state IDLE, counters 0, psg_cs_n=1, psg_wr_n=1, psg_addr=0, psg_din=0, rd_data=0, rd_valid=0, busy=0, req_ready=1.
REQ-034 rst asserted mid-access SHALL abort the access on that edge, discard all queued requests, and produce no rd_valid.

Verification
REQ-035 cen=1, HOLD=2, GAP=1; write addr 7 data 0x38 -> cs_n low 3 cycles; wr_n low exactly cycles 2-3; addr=7 and din=0x38 stable 4 cycles; busy clears after cycle 4.
REQ-036 Read addr 8 with psg_dout=0x1F -> wr_n stays 1; rd_valid single pulse with rd_data=0x1F, one cycle after the last STROBE cycle.
REQ-037 Push 5 writes back-to-back with DEPTH=4 and cen=0 -> req_ready low after the 4th; the 5th is held until cen=1 and a pop occurs; all 5 issue in order with no lost entries.
REQ-038 cen asserted every 4th clk -> each phase duration scales to 4x clk; psg_* change only on cen edges.
REQ-039 rst asserted during STROBE of a read with 2 entries queued -> next cycle cs_n=1, wr_n=1, busy=0, req_ready=1, no rd_valid.
REQ-040 Write to addr 0xD followed immediately by a second write to 0xD -> each access shows wr_n 1->0 while cs_n=0 (two distinct falling edges), separated by GAP cen ticks with cs_n=1.
